// File: rtl/klp32_mmio_pkg.sv
// +--------------------------------------------------------------------+
// | klp32_mmio_pkg: register offsets, bit indices, UART TX FSM states   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package klp32_mmio_pkg;

  localparam logic [1:0] TXDATA_OFF  = 2'd0;
  localparam logic [1:0] STATUS_OFF  = 2'd1;
  localparam logic [1:0] CTRL_OFF    = 2'd2;
  localparam logic [1:0] BAUDDIV_OFF = 2'd3;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_PARITY_BIT = 2;
  localparam int CTRL_ODD_BIT    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +--------------------------------------------------------------------+
// | uart_tx_fifo: byte-wide synchronous FIFO; dout_o valid while !empty |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [7:0]                      din_i,
  output logic [7:0]                      dout_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]     PTR_ONE  = 1;
  localparam logic [AW:0]       CNT_ONE  = 1;
  localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// +--------------------------------------------------------------------+
// | mmio_uart_tx: MMIO 8N1 UART transmitter with TX FIFO and irq        |
// | Optional parity via `define UART_TX_PARITY_EN.        Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module mmio_uart_tx
  import klp32_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h3;
`endif

  logic           sel;
  logic           wr_en;
  logic [1:0]     offset;
  logic           push;
  logic           pop;
  logic           ovf_set;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic [6:0]     count7;
  logic [7:0]     fifo_dout;
  logic           bit_end;
  logic           par_en;
  logic           par_odd;
  logic           unused_bits;

  logic [3:0]     ctrl_q;
  logic [15:0]    div_q;
  logic           ovf_q;
  uart_tx_state_e state_q;
  logic [15:0]    cnt_q;
  logic [7:0]     shreg_q;
  logic [2:0]     bitidx_q;
  logic           par_q;
  logic           tx_q;
  logic           irq_q;

  assign sel     = bus_cs & (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset  = bus_addr[3:2];
  assign wr_en   = sel & bus_wr;
  assign push    = wr_en & (offset == TXDATA_OFF);
  assign bit_end = (cnt_q == 16'd0);
  assign pop     = ctrl_q[CTRL_EN_BIT] & ~empty &
                   ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign ovf_set = push & full & ~pop;
  assign count7  = 7'(count);
  assign uart_tx = tx_q;
  assign irq     = irq_q;
  assign unused_bits = ^{bus_addr[1:0], bus_wr_data[31:16]};

`ifdef UART_TX_PARITY_EN
  assign par_en  = ctrl_q[CTRL_PARITY_BIT];
  assign par_odd = ctrl_q[CTRL_ODD_BIT];
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus_wr_data[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= 4'h0;
      div_q  <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en && offset == CTRL_OFF)    ctrl_q <= bus_wr_data[3:0] & CTRL_WMASK;
      if (wr_en && offset == BAUDDIV_OFF) div_q  <= bus_wr_data[15:0];
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (wr_en && offset == STATUS_OFF && bus_wr_data[STAT_OVF_BIT])
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    bus_rd_data = 32'h0;
    if (sel && bus_rd) begin
      case (offset)
        STATUS_OFF: begin
          bus_rd_data[STAT_BUSY_BIT]          = (state_q != IDLE);
          bus_rd_data[STAT_FULL_BIT]          = full;
          bus_rd_data[STAT_EMPTY_BIT]         = empty;
          bus_rd_data[STAT_OVF_BIT]           = ovf_q;
          bus_rd_data[STAT_COUNT_LSB +: 7]    = count7;
        end
        CTRL_OFF:    bus_rd_data[3:0]  = ctrl_q;
        BAUDDIV_OFF: bus_rd_data[15:0] = div_q;
        default:     bus_rd_data       = 32'h0;
      endcase
    end
  end

  // The baud down-counter reloads from div_q only at bit boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      shreg_q  <= 8'h00;
      bitidx_q <= 3'd0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= ctrl_q[CTRL_IRQ_EN_BIT] & empty & (state_q == IDLE);
      if (state_q != IDLE && !bit_end) cnt_q <= cnt_q - 16'd1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shreg_q <= fifo_dout;
            par_q   <= ^fifo_dout;
            cnt_q   <= div_q;
          end
        end
        START: begin
          if (bit_end) begin
            state_q  <= DATA;
            tx_q     <= shreg_q[0];
            shreg_q  <= {1'b0, shreg_q[7:1]};
            bitidx_q <= 3'd0;
            cnt_q    <= div_q;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= div_q;
            if (bitidx_q == 3'd7) begin
              if (par_en) begin
                state_q <= PARITY;
                tx_q    <= par_q ^ par_odd;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q     <= shreg_q[0];
              shreg_q  <= {1'b0, shreg_q[7:1]};
              bitidx_q <= bitidx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            cnt_q   <= div_q;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
              shreg_q <= fifo_dout;
              par_q   <= ^fifo_dout;
              cnt_q   <= div_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// +--------------------------------------------------------------------+
// | tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx      |
// | Parity frames exercised when UART_TX_PARITY_EN is defined. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_cs;
  logic        bus_wr;
  logic        bus_rd;
  logic        uart_tx;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  mmio_uart_tx dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_cs      (bus_cs),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .uart_tx     (uart_tx),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_raw(input logic [31:0] addr, input logic [31:0] data, input logic cs);
    @(negedge clk);
    bus_cs = cs; bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = addr; bus_wr_data = data;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    wr_raw(addr, data, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic cs, output logic [31:0] data);
    bus_cs = cs; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = addr;
    #1;
    data = bus_rd_data;
    bus_cs = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic wait_low(input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk); #1;
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check(tag, {63'd0, found}, 64'd1);
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic ok);
    b  = 8'h00;
    ok = 1'b0;
    wait_low("rx_start_timeout");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      b[i] = uart_tx;
    end
    @(negedge clk); #1;
    ok = (uart_tx === 1'b1);
  endtask

  logic [31:0] d;
  logic [63:0] txv, busyv;
  logic        irqv, anylow, ok;
  logic [7:0]  b;

  initial begin
    reset = 1'b1; bus_addr = 32'h0; bus_wr_data = 32'h0;
    bus_cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_rd_idle", {32'd0, bus_rd_data}, 64'd0);
    rd(BASE + 32'h4, 1'b1, d); check("rst_status",  {32'd0, d}, 64'h4);
    rd(BASE + 32'h8, 1'b1, d); check("rst_ctrl",    {32'd0, d}, 64'h0);
    rd(BASE + 32'hC, 1'b1, d); check("rst_bauddiv", {32'd0, d}, 64'd867);

    // Single 8N1 frame of 0x55 at 4 cycles per bit
    wr(BASE + 32'hC, 32'd3);
    wr(BASE + 32'h8, 32'd1);
    wr(BASE + 32'h0, 32'h55);
    rd(BASE + 32'h0, 1'b1, d); check("t1_txdata_reads0", {32'd0, d}, 64'h0);
    check("t1_high_after_write", {63'd0, uart_tx}, 64'd1);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = BASE + 32'h4;
    txv = '0; busyv = '0; irqv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      txv   = {txv[62:0], uart_tx};
      busyv = {busyv[62:0], bus_rd_data[0]};
      irqv  = irqv | irq;
    end
    check("t1_frame_bits", txv, 64'h0F_0F0F_0F0F);
    check("t1_busy_40", busyv, 64'hFF_FFFF_FFFF);
    check("t1_irq_low", {63'd0, irqv}, 64'd0);
    @(negedge clk); #1;
    check("t1_line_idle", {63'd0, uart_tx}, 64'd1);
    check("t1_status_after", {32'd0, bus_rd_data}, 64'h4);
    bus_cs = 1'b0; bus_rd = 1'b0;

    // Overflow: 9 pushes into an 8-deep FIFO with TX disabled
    wr(BASE + 32'h8, 32'd0);
    for (int i = 1; i <= 9; i++) wr(BASE + 32'h0, 32'(i));
    rd(BASE + 32'h4, 1'b1, d); check("t2_status_ovf", {32'd0, d}, 64'h80A);
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, 1'b1, d); check("t2_ovf_cleared", {32'd0, d}, 64'h802);
    wr(BASE + 32'hC, 32'd0);
    wr(BASE + 32'h8, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx_byte(b, ok);
      check($sformatf("t2_byte%0d", i), {55'd0, ok, b}, {55'd0, 1'b1, 8'(i + 1)});
    end
    anylow = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      anylow = anylow | ~uart_tx;
    end
    check("t2_no_ninth_byte", {63'd0, anylow}, 64'd0);
    rd(BASE + 32'h4, 1'b1, d); check("t2_status_drained", {32'd0, d}, 64'h4);

    // Back-to-back frames at 1 cycle per bit, then interrupt
    wr(BASE + 32'h8, 32'd0);
    wr(BASE + 32'h0, 32'hA5);
    wr(BASE + 32'h0, 32'h3C);
    wr(BASE + 32'h8, 32'd3);
    wait_low("t3_start_timeout");
    txv = {63'd0, uart_tx}; irqv = irq;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk); #1;
      txv  = {txv[62:0], uart_tx};
      irqv = irqv | irq;
    end
    check("t3_two_frames", txv, 64'h5_2C79);
    check("t3_irq_during", {63'd0, irqv}, 64'd0);
    @(negedge clk); #1;
    check("t3_irq_not_yet", {63'd0, irq}, 64'd0);
    @(negedge clk); #1;
    check("t3_irq_rise", {63'd0, irq}, 64'd1);

    // Decode boundaries
    rd(BASE + 32'h10, 1'b1, d); check("t4_rd_out_of_window", {32'd0, d}, 64'h0);
    rd(BASE + 32'h8,  1'b0, d); check("t4_rd_cs_low", {32'd0, d}, 64'h0);
    bus_cs = 1'b1; bus_rd = 1'b0; bus_addr = BASE + 32'h8; #1;
    check("t4_rd_strobe_low", {32'd0, bus_rd_data}, 64'h0);
    bus_cs = 1'b0;
    wr(BASE + 32'h18, 32'h0);
    wr_raw(BASE + 32'hC, 32'h55, 1'b0);
    wr_raw(BASE + 32'h0, 32'h00, 1'b0);
    rd(BASE + 32'h8, 1'b1, d); check("t4_ctrl_kept",    {32'd0, d}, 64'h3);
    rd(BASE + 32'hC, 1'b1, d); check("t4_bauddiv_kept", {32'd0, d}, 64'h0);
    rd(BASE + 32'h4, 1'b1, d); check("t4_status_kept",  {32'd0, d}, 64'h4);
    wr(BASE + 32'hC, 32'hFFFF_0007);
    rd(BASE + 32'hC, 1'b1, d); check("t4_bauddiv_mask", {32'd0, d}, 64'h7);
    wr(BASE + 32'h8, 32'hFFFF_FFFF);
    rd(BASE + 32'h8, 1'b1, d);
`ifdef UART_TX_PARITY_EN
    check("t4_ctrl_mask", {32'd0, d}, 64'hF);
`else
    check("t4_ctrl_mask", {32'd0, d}, 64'h3);
`endif

    // Reset during DATA bit 3
    wr(BASE + 32'h8, 32'd0);
    wr(BASE + 32'hC, 32'd3);
    wr(BASE + 32'h0, 32'h00);
    wr(BASE + 32'h0, 32'hFF);
    wr(BASE + 32'h8, 32'd1);
    wait_low("t5_start_timeout");
    repeat (17) @(negedge clk);
    #1;
    check("t5_low_in_bit3", {63'd0, uart_tx}, 64'd0);
    reset = 1'b1;
    #1;
    check("t5_async_high", {63'd0, uart_tx}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    rd(BASE + 32'h4, 1'b1, d); check("t5_status", {32'd0, d}, 64'h4);
    rd(BASE + 32'h8, 1'b1, d); check("t5_ctrl",   {32'd0, d}, 64'h0);
    check("t5_line_idle", {63'd0, uart_tx}, 64'd1);

`ifdef UART_TX_PARITY_EN
    // Even and odd parity frames of 0x07 at 2 cycles per bit
    wr(BASE + 32'hC, 32'd1);
    wr(BASE + 32'h8, 32'h5);
    wr(BASE + 32'h0, 32'h07);
    wait_low("t6_even_timeout");
    txv = {63'd0, uart_tx};
    for (int k = 1; k < 22; k++) begin
      @(negedge clk); #1;
      txv = {txv[62:0], uart_tx};
    end
    check("t6_even_frame", txv, {42'd0, 22'b0011111100000000001111});
    @(negedge clk); #1;
    rd(BASE + 32'h4, 1'b1, d); check("t6_even_done", {32'd0, d}, 64'h4);
    wr(BASE + 32'h8, 32'hD);
    wr(BASE + 32'h0, 32'h07);
    wait_low("t6_odd_timeout");
    txv = {63'd0, uart_tx};
    for (int k = 1; k < 22; k++) begin
      @(negedge clk); #1;
      txv = {txv[62:0], uart_tx};
    end
    check("t6_odd_frame", txv, {42'd0, 22'b0011111100000000000011});
    @(negedge clk); #1;
    rd(BASE + 32'h4, 1'b1, d); check("t6_odd_done", {32'd0, d}, 64'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
